fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer for the CPU core. It drives the `count`/`load` controls of the program counter and runs the req/ack handshake with instruction memory. It holds the fetched word in an instruction register and presents it to decode over a valid/ready interface. It sits between the program counter, instruction memory and the decode stage, and is the only block that drives the counter's control inputs.

## Interface
- N, 8, instruction address width (must match the program counter width)
- W, 16, instruction word width
- BOOT_ADDR, 0, address loaded into the program counter on `start`

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins execution from BOOT_ADDR (honoured in IDLE/HALTED only)
- halt  in  1  one-cycle pulse from execute; stop fetching
- jump  in  1  one-cycle pulse from execute; redirect fetch
- jump_addr  in  N  jump target, valid with `jump`
- pc_addr  in  N  current program counter value
- pc_count  out  1  program counter increment
- pc_load  out  1  program counter load
- pc_addr_in  out  N  value to load (BOOT_ADDR or jump_addr)
- imem_req  out  1  instruction memory request
- imem_addr  out  N  request address, registered
- imem_ack  in  1  memory accepted the request and `imem_data` is valid
- imem_data  in  W  instruction word
- inst_valid  out  1  `inst` is valid for decode
- inst_ready  in  1  decode accepts `inst`
- inst  out  W  instruction register
- inst_addr  out  N  address `inst` was fetched from
- running  out  1  high in FETCH/ISSUE
- halted  out  1  high in HALTED

## Operation
- States:
  - IDLE: after reset.
  - FETCH: `imem_req` high; waiting for `imem_ack`.
  - ISSUE: `inst_valid` high; waiting for `inst_ready`.
  - HALTED: fetching stopped.
- Transitions out of IDLE/HALTED:
  - `start` in IDLE/HALTED: `pc_load`=1 and `pc_addr_in`=BOOT_ADDR for that cycle; go to FETCH. `halted` clears.
- FETCH:
  - On entry, `imem_addr` <= `pc_addr`. It is held constant and `imem_req` stays high until `imem_ack`; a request is never withdrawn.
  - On `imem_ack`: `inst` <= `imem_data` and `inst_addr` <= `imem_addr`. Then:
    - squash flag set: re-enter FETCH with the new `pc_addr`;
    - halt-pending flag set: go to HALTED;
    - otherwise: go to ISSUE.
- ISSUE:
  - When `inst_valid` & `inst_ready`, `pc_count`=1 that cycle and the next state is FETCH.
- `jump` in FETCH/ISSUE:
  - `pc_load`=1 and `pc_addr_in`=`jump_addr` that cycle; `pc_count` is forced 0 (load wins).
  - In FETCH, the squash flag is set.
  - In ISSUE, `inst_valid` drops next cycle and the state goes to FETCH. A handshake completing in the same cycle still counts as accepted.
- `halt` in FETCH/ISSUE:
  - In FETCH, the halt-pending flag is set and the outstanding request completes; its data is discarded.
  - In ISSUE, go to HALTED next cycle. A same-cycle handshake is still accepted, with no `pc_count`.
  - `halt` has priority over `jump`: if both are high, no `pc_load` occurs.
- `jump`/`halt` in IDLE/HALTED are ignored. `start` in FETCH/ISSUE is ignored.
- The squash and halt-pending flags clear when leaving FETCH.

## Timing
- Reset (asynchronous):
  - State=IDLE.
  - `pc_count`, `pc_load`, `imem_req`, `inst_valid`, `running`, `halted` = 0.
  - `pc_addr_in`, `imem_addr`, `inst`, `inst_addr` = 0.
  - Squash and halt-pending flags = 0.
- Reset mid-handshake abandons it. Memory must tolerate the dropped `imem_req`.
- `pc_count` and `pc_load` are combinational from state and inputs, and are single-cycle pulses.
- `imem_req`, `imem_addr`, `inst_valid`, `inst`, `inst_addr`, `running`, `halted` are registered.
- Cycle counts:
  - `start` at cycle 0: FETCH at cycle 1, with `imem_addr`=BOOT_ADDR.
  - With `imem_ack` in the first FETCH cycle, `inst_valid` rises the next cycle.
  - Peak throughput is one instruction per 2 cycles (zero-wait memory, `inst_ready` tied high).
- Address wrap: the counter wraps from 2^N-1 to 0 with no special handling here.

## Test plan
- Sequential run:
  - Stimulus: reset, `start`, memory returns word = address+0x100 with zero wait, `inst_ready`=1.
  - Required: `inst` sequence 0x100, 0x101, 0x102, one every 2 cycles; `inst_addr` = 0, 1, 2; one `pc_count` per instruction.
- Wait states and backpressure:
  - Stimulus: `imem_ack` delayed 3 cycles; `inst_ready` low for 4 cycles.
  - Required: `imem_addr` and `imem_req` stable throughout; `inst` stable and `inst_valid` held until the handshake; no extra `pc_count`.
- Jump in ISSUE:
  - Stimulus: `jump` with `jump_addr`=0x40 while `inst_valid`=1 at address 5.
  - Required: `pc_load`=1 and `pc_count`=0 that cycle; next FETCH uses `imem_addr`=0x40; address 6 is never requested.
- Jump in FETCH:
  - Stimulus: `jump` to 0x20 while a request to address 3 waits 2 cycles for ack.
  - Required: address 3 data is never issued; the next request is to 0x20.
- Halt and restart:
  - Stimulus: `halt` during FETCH with a pending ack, then `start`.
  - Required: the request completes; HALTED with `halted`=1 and `inst_valid`=0; `start` reloads BOOT_ADDR and resumes.
- Async reset mid-ISSUE:
  - Stimulus: assert `rst` while in ISSUE.
  - Required: all outputs are 0 immediately; IDLE; no fetch until `start`.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Drives the program counter's
// count/load controls, the instruction-memory req/ack handshake and the decode valid/ready port.
`default_nettype none

module fetch_ctrl #(
  parameter int             N         = 8,
  parameter int             W         = 16,
  parameter logic [N-1:0]   BOOT_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt,
  input  logic         jump,
  input  logic [N-1:0] jump_addr,
  input  logic [N-1:0] pc_addr,
  output logic         pc_count,
  output logic         pc_load,
  output logic [N-1:0] pc_addr_in,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_data,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [W-1:0] inst,
  output logic [N-1:0] inst_addr,
  output logic         running,
  output logic         halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [N-1:0] PC_STEP = N'(1);

  state_e         state_q;
  logic           squash_q;
  logic           halt_pend_q;
  logic           imem_req_q;
  logic [N-1:0]   imem_addr_q;
  logic           inst_valid_q;
  logic [W-1:0]   inst_q;
  logic [N-1:0]   inst_addr_q;
  logic           running_q;
  logic           halted_q;

  logic           start_go_d;
  logic           jump_go_d;
  logic           handshake_d;

  always_comb begin
    start_go_d  = (state_q == S_IDLE || state_q == S_HALTED) && start;
    jump_go_d   = (state_q == S_FETCH || state_q == S_ISSUE) && jump && !halt;
    handshake_d = (state_q == S_ISSUE) && inst_valid_q && inst_ready;
  end

  // PC controls are combinational; held low while reset is asserted so outputs read 0 immediately.
  assign pc_load    = !rst && (start_go_d || jump_go_d);
  assign pc_count   = !rst && handshake_d && !jump && !halt;
  assign pc_addr_in = rst        ? '0 :
                      start_go_d ? BOOT_ADDR :
                      jump_go_d  ? jump_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      squash_q     <= 1'b0;
      halt_pend_q  <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state_q     <= S_FETCH;
            imem_req_q  <= 1'b1;
            imem_addr_q <= BOOT_ADDR;
            running_q   <= 1'b1;
            halted_q    <= 1'b0;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            inst_q      <= imem_data;
            inst_addr_q <= imem_addr_q;
            squash_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            // A halt arriving alongside a squash wins: fetching stops rather than refetching.
            if (halt_pend_q || halt) begin
              state_q    <= S_HALTED;
              imem_req_q <= 1'b0;
              running_q  <= 1'b0;
              halted_q   <= 1'b1;
            end else if (squash_q || jump) begin
              state_q     <= S_FETCH;
              imem_addr_q <= jump ? jump_addr : pc_addr;
            end else begin
              state_q      <= S_ISSUE;
              imem_req_q   <= 1'b0;
              inst_valid_q <= 1'b1;
            end
          end else if (halt) begin
            halt_pend_q <= 1'b1;
          end else if (jump) begin
            squash_q <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (halt) begin
            state_q      <= S_HALTED;
            inst_valid_q <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b1;
          end else if (jump) begin
            state_q      <= S_FETCH;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            imem_addr_q  <= jump_addr;
          end else if (inst_ready) begin
            // The PC increments on this same edge, so the next fetch address is pc_addr+1.
            state_q      <= S_FETCH;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
            imem_addr_q  <= pc_addr + PC_STEP;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule

`default_nettype wire
